// File: rtl/fan_pwm_meter.sv
// fan_pwm_meter: receive side of the fan PWM link.
// Measures period and high time of pwm_in in clk cycles and turns them into a
// duty code on the 0..2^N-1 scale. A line without rising edges for TIMEOUT
// cycles is reported as stalled, with the duty taken from the held level.
module fan_pwm_meter #(
  parameter int unsigned SYS_FREQ = 125,
  parameter int unsigned N        = 12,
  parameter int unsigned CNT_W    = 21,
  parameter int unsigned MIN_FREQ = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pwm_in,
  output logic [N-1:0]     duty,
  output logic [CNT_W-1:0] period,
  output logic             duty_valid,
  output logic             stall,
  output logic             busy
);

  localparam int unsigned       TIMEOUT_I = SYS_FREQ * 1_000_000 / MIN_FREQ;
  localparam logic [CNT_W-1:0]  TIMEOUT   = CNT_W'(TIMEOUT_I);
  // Shortest period that is ever handed to the divider; anything shorter is
  // discarded outright rather than reported.
  localparam logic [CNT_W-1:0]  MIN_P     = CNT_W'(N + 3);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam int unsigned       STEP_W    = $clog2(N + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N);

  typedef enum logic [1:0] {ARM, MEAS, DIV} state_t;
  state_t state_q, state_d;

  logic              sync1, sync2, lvl_d;
  logic              rise;
  logic [CNT_W-1:0]  prd_cnt, hi_cnt;
  logic [CNT_W-1:0]  p_reg;
  logic [CNT_W:0]    rem;
  logic [N-1:0]      quo;
  logic [STEP_W-1:0] step;

  logic              snap, timeout_hit, div_last;
  logic [CNT_W:0]    trial, trial_sub;
  logic              trial_ge;
  logic [N:0]        quo_next;

  // 2-FF synchronizer plus one delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      lvl_d <= sync2;
    end
  end

  assign rise = sync2 & ~lvl_d;

  // Period / high-time counters, restarted at 1 on every synced rising edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prd_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      prd_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (prd_cnt != CNT_MAX) prd_cnt <= prd_cnt + CNT_W'(1);
      if (sync2 && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CNT_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ARM;
    else          state_q <= state_d;
  end

  // FSM next state; a rising edge wins over a same-cycle timeout
  always_comb begin
    state_d     = state_q;
    snap        = 1'b0;
    timeout_hit = 1'b0;
    div_last    = 1'b0;
    case (state_q)
      ARM: begin
        if (rise) state_d = MEAS;
      end
      MEAS: begin
        if (rise) begin
          if (prd_cnt >= MIN_P) begin
            snap    = 1'b1;
            state_d = DIV;
          end
        end else if (prd_cnt >= TIMEOUT) begin
          timeout_hit = 1'b1;
          state_d     = ARM;
        end
      end
      DIV: begin
        if (step == LAST_STEP) begin
          div_last = 1'b1;
          state_d  = MEAS;
        end
      end
      default: state_d = ARM;
    endcase
  end

  // One restoring-division step: step 0 compares H itself, later steps shift
  always_comb begin
    trial     = (step == '0) ? rem : {rem[CNT_W-1:0], 1'b0};
    trial_ge  = (trial >= {1'b0, p_reg});
    trial_sub = trial - {1'b0, p_reg};
    quo_next  = {quo, trial_ge};
  end

  // Divider datapath: load snapshot on a rising edge, iterate while in DIV
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_reg <= '0;
      rem   <= '0;
      quo   <= '0;
      step  <= '0;
    end else if (snap) begin
      p_reg <= prd_cnt;
      rem   <= {1'b0, hi_cnt};
      quo   <= '0;
      step  <= '0;
    end else if (state_q == DIV) begin
      rem   <= trial_ge ? trial_sub : trial;
      quo   <= quo_next[N-1:0];
      step  <= step + STEP_W'(1);
    end
  end

  // Result registers; held between updates, strobe for exactly one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty       <= '0;
      period     <= '0;
      duty_valid <= 1'b0;
      stall      <= 1'b1;
    end else begin
      duty_valid <= 1'b0;
      if (div_last) begin
        // Q can only reach 2^N when H == P; clamp to full scale
        duty       <= quo_next[N] ? {N{1'b1}} : quo_next[N-1:0];
        period     <= p_reg;
        stall      <= 1'b0;
        duty_valid <= 1'b1;
      end else if (timeout_hit) begin
        duty       <= {N{sync2}};
        period     <= '0;
        stall      <= 1'b1;
        duty_valid <= 1'b1;
      end
    end
  end

  assign busy = (state_q == DIV);

endmodule
